// File: rtl/status_reg.sv
// 6502 processor status register with NMI edge detect and IRQ masking.
// Optional STATUS_IRQ_SYNC_EN adds two-flop synchronizers on nmi_n/irq_n.
module status_reg #(
    parameter logic [7:0] RESET_P = 8'h24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_zero,
    input  logic       alu_negative,
    input  logic       alu_overflow,
    input  logic       alu_c_out,
    input  logic [3:0] flag_we,
    input  logic [7:0] bus_in,
    input  logic       p_load,
    input  logic       set_c,
    input  logic       clr_c,
    input  logic       set_d,
    input  logic       clr_d,
    input  logic       set_i,
    input  logic       clr_i,
    input  logic       clr_v,
    input  logic       brk_push,
    output logic [7:0] p_out,
    output logic       c_in,
    output logic       bcd,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       poll,
    output logic       int_req,
    output logic       int_is_nmi,
    input  logic       int_ack
);

    logic n_q, v_q, d_q, i_q, z_q, c_q;
    logic n_d, v_d, d_d, i_d, z_d, c_d;
    logic nmi_s, irq_s;
    logic nmi_prev, nmi_pend;
    logic nmi_edge;

`ifdef STATUS_IRQ_SYNC_EN
    logic [1:0] nmi_sync, irq_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nmi_sync <= 2'b11;
            irq_sync <= 2'b11;
        end else begin
            nmi_sync <= {nmi_sync[0], nmi_n};
            irq_sync <= {irq_sync[0], irq_n};
        end
    end

    assign nmi_s = nmi_sync[1];
    assign irq_s = irq_sync[1];
`else
    assign nmi_s = nmi_n;
    assign irq_s = irq_n;
`endif

    assign nmi_edge = nmi_prev & ~nmi_s;

    // Per-flag priority: load, ack (I only), clear, set, ALU, hold
    always_comb begin
        n_d = n_q;
        v_d = v_q;
        d_d = d_q;
        i_d = i_q;
        z_d = z_q;
        c_d = c_q;
        if (p_load) begin
            n_d = bus_in[7];
            v_d = bus_in[6];
            d_d = bus_in[3];
            i_d = bus_in[2];
            z_d = bus_in[1];
            c_d = bus_in[0];
        end else begin
            if (flag_we[3]) n_d = alu_negative;
            if (clr_v) v_d = 1'b0;
            else if (flag_we[2]) v_d = alu_overflow;
            if (clr_d) d_d = 1'b0;
            else if (set_d) d_d = 1'b1;
            if (int_ack) i_d = 1'b1;
            else if (clr_i) i_d = 1'b0;
            else if (set_i) i_d = 1'b1;
            if (flag_we[1]) z_d = alu_zero;
            if (clr_c) c_d = 1'b0;
            else if (set_c) c_d = 1'b1;
            else if (flag_we[0]) c_d = alu_c_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q <= RESET_P[7];
            v_q <= RESET_P[6];
            d_q <= RESET_P[3];
            i_q <= RESET_P[2];
            z_q <= RESET_P[1];
            c_q <= RESET_P[0];
        end else begin
            n_q <= n_d;
            v_q <= v_d;
            d_q <= d_d;
            i_q <= i_d;
            z_q <= z_d;
            c_q <= c_d;
        end
    end

    // Poll samples I before this cycle's update for one-instruction CLI/SEI lag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nmi_prev   <= 1'b1;
            nmi_pend   <= 1'b0;
            int_req    <= 1'b0;
            int_is_nmi <= 1'b0;
        end else begin
            nmi_prev <= nmi_s;
            if (int_ack && int_is_nmi) begin
                nmi_pend <= nmi_edge;
            end else if (nmi_edge) begin
                nmi_pend <= 1'b1;
            end
            if (int_ack) begin
                int_req <= 1'b0;
            end else if (poll && !int_req) begin
                int_req    <= nmi_pend | (~irq_s & ~i_q);
                int_is_nmi <= nmi_pend;
            end
        end
    end

    assign p_out = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
    assign c_in  = c_q;
    assign bcd   = d_q;

endmodule

// File: tb/tb_status_reg.sv
// Scoreboard bench for status_reg: stimulus queues expectations,
// a negedge monitor pops and compares them when they fall due.
module tb_status_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_zero, alu_negative, alu_overflow, alu_c_out;
    logic [3:0] flag_we;
    logic [7:0] bus_in;
    logic       p_load;
    logic       set_c, clr_c, set_d, clr_d, set_i, clr_i, clr_v;
    logic       brk_push;
    logic [7:0] p_out;
    logic       c_in, bcd;
    logic       nmi_n, irq_n, poll;
    logic       int_req, int_is_nmi, int_ack;

    typedef struct {
        string      name;
        int         due;
        logic [7:0] p;
        logic       req;
        logic       nmi;
        logic       chk_nmi;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    status_reg dut (
        .clk(clk), .reset(reset),
        .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow), .alu_c_out(alu_c_out),
        .flag_we(flag_we), .bus_in(bus_in), .p_load(p_load),
        .set_c(set_c), .clr_c(clr_c), .set_d(set_d), .clr_d(clr_d),
        .set_i(set_i), .clr_i(clr_i), .clr_v(clr_v),
        .brk_push(brk_push), .p_out(p_out), .c_in(c_in), .bcd(bcd),
        .nmi_n(nmi_n), .irq_n(irq_n), .poll(poll),
        .int_req(int_req), .int_is_nmi(int_is_nmi), .int_ack(int_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_at(string nm, int dly, logic [7:0] p,
                                      logic req, logic nmi, logic chk);
        exp_t e;
        e.name = nm;
        e.due = cyc + dly;
        e.p = p;
        e.req = req;
        e.nmi = nmi;
        e.chk_nmi = chk;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic bad;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            vectors++;
            bad = (p_out !== e.p) || (c_in !== e.p[0]) || (bcd !== e.p[3])
                || (int_req !== e.req) || (e.chk_nmi && int_is_nmi !== e.nmi);
            if (bad) begin
                miscompares++;
                $display("FAIL %s: got p_out=%h c_in=%b bcd=%b int_req=%b int_is_nmi=%b, want p_out=%h int_req=%b int_is_nmi=%b",
                         e.name, p_out, c_in, bcd, int_req, int_is_nmi,
                         e.p, e.req, e.nmi);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        flag_we = 4'h0;
        p_load = 1'b0;
        {set_c, clr_c, set_d, clr_d, set_i, clr_i, clr_v} = 7'b0;
        poll = 1'b0;
        int_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        {alu_zero, alu_negative, alu_overflow, alu_c_out} = 4'b0;
        flag_we = 4'h0;
        bus_in = 8'h00;
        p_load = 1'b0;
        {set_c, clr_c, set_d, clr_d, set_i, clr_i, clr_v} = 7'b0;
        brk_push = 1'b0;
        nmi_n = 1'b1;
        irq_n = 1'b1;
        poll = 1'b0;
        int_ack = 1'b0;

        tick();
        expect_at("reset", 0, 8'h24, 1'b0, 1'b0, 1'b1);
        tick();
        brk_push = 1'b1;
        expect_at("reset_brk", 0, 8'h34, 1'b0, 1'b0, 1'b1);
        tick();
        brk_push = 1'b0;
        reset = 1'b0;
        tick();

        flag_we = 4'hF;
        {alu_negative, alu_overflow, alu_zero, alu_c_out} = 4'b1011;
        expect_at("alu_all", 1, 8'hA7, 1'b0, 1'b0, 1'b0);
        tick();
        clr_c = 1'b1;
        flag_we = 4'b0001;
        expect_at("clc_over_alu", 1, 8'hA6, 1'b0, 1'b0, 1'b0);
        tick();
        set_d = 1'b1;
        expect_at("sed", 1, 8'hAE, 1'b0, 1'b0, 1'b0);
        tick();
        set_d = 1'b1;
        clr_d = 1'b1;
        expect_at("set_clr_d", 1, 8'hA6, 1'b0, 1'b0, 1'b0);
        tick();
        bus_in = 8'hFF;
        p_load = 1'b1;
        expect_at("pload_ff", 1, 8'hEF, 1'b0, 1'b0, 1'b0);
        tick();
        bus_in = 8'h00;
        p_load = 1'b1;
        set_c = 1'b1;
        expect_at("pload_over_sec", 1, 8'h20, 1'b0, 1'b0, 1'b0);
        tick();

        irq_n = 1'b0;
        poll = 1'b1;
        expect_at("irq_req", 1, 8'h20, 1'b1, 1'b0, 1'b1);
        tick();
        int_ack = 1'b1;
        expect_at("irq_ack", 1, 8'h24, 1'b0, 1'b0, 1'b0);
        tick();
        poll = 1'b1;
        expect_at("irq_masked", 1, 8'h24, 1'b0, 1'b0, 1'b0);
        tick();
        clr_i = 1'b1;
        poll = 1'b1;
        expect_at("cli_same_poll", 1, 8'h20, 1'b0, 1'b0, 1'b0);
        tick();
        poll = 1'b1;
        expect_at("cli_next_poll", 1, 8'h20, 1'b1, 1'b0, 1'b1);
        tick();
        int_ack = 1'b1;
        irq_n = 1'b1;
        expect_at("irq_ack2", 1, 8'h24, 1'b0, 1'b0, 1'b0);
        tick();

        nmi_n = 1'b0;
        expect_at("nmi_no_poll", 1, 8'h24, 1'b0, 1'b0, 1'b0);
        tick();
        poll = 1'b1;
        expect_at("nmi_req", 1, 8'h24, 1'b1, 1'b1, 1'b1);
        tick();
        poll = 1'b1;
        expect_at("poll_while_req", 1, 8'h24, 1'b1, 1'b1, 1'b1);
        tick();
        int_ack = 1'b1;
        expect_at("nmi_ack", 1, 8'h24, 1'b0, 1'b0, 1'b0);
        tick();
        poll = 1'b1;
        expect_at("nmi_held_low", 1, 8'h24, 1'b0, 1'b0, 1'b0);
        tick();
        nmi_n = 1'b1;
        tick();
        nmi_n = 1'b0;
        tick();
        poll = 1'b1;
        expect_at("nmi_req2", 1, 8'h24, 1'b1, 1'b1, 1'b1);
        tick();
        nmi_n = 1'b1;
        tick();
        nmi_n = 1'b0;
        int_ack = 1'b1;
        expect_at("nmi_edge_at_ack", 1, 8'h24, 1'b0, 1'b0, 1'b0);
        tick();
        poll = 1'b1;
        expect_at("nmi_again", 1, 8'h24, 1'b1, 1'b1, 1'b1);
        tick();
        int_ack = 1'b1;
        expect_at("nmi_ack3", 1, 8'h24, 1'b0, 1'b0, 1'b0);
        tick();

        bus_in = 8'h00;
        p_load = 1'b1;
        nmi_n = 1'b1;
        expect_at("pload_00", 1, 8'h20, 1'b0, 1'b0, 1'b0);
        tick();
        nmi_n = 1'b0;
        irq_n = 1'b0;
        tick();
        poll = 1'b1;
        expect_at("nmi_wins", 1, 8'h20, 1'b1, 1'b1, 1'b1);
        tick();
        int_ack = 1'b1;
        expect_at("nmi_wins_ack", 1, 8'h24, 1'b0, 1'b0, 1'b0);
        tick();
        clr_i = 1'b1;
        tick();
        poll = 1'b1;
        expect_at("irq_after_nmi", 1, 8'h20, 1'b1, 1'b0, 1'b1);
        tick();
        int_ack = 1'b1;
        irq_n = 1'b1;
        expect_at("irq_after_ack", 1, 8'h24, 1'b0, 1'b0, 1'b0);
        tick();
        clr_i = 1'b1;
        irq_n = 1'b0;
        tick();
        irq_n = 1'b1;
        poll = 1'b1;
        expect_at("irq_released", 1, 8'h20, 1'b0, 1'b0, 1'b0);
        tick();

        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        #1;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: never checked, due cycle %0d, now %0d",
                     e.name, e.due, cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        if (vectors < 12) begin
            $display("FAIL too few vectors: %0d", vectors);
            miscompares++;
        end
        if (miscompares != 0) begin
            $display("FAIL %0d miscompares", miscompares);
            $fatal(1);
        end else begin
            $display("PASS");
        end
        $finish;
    end

endmodule
